// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - valid/ready beat stream carrying framed FIFO read data
// Parameters: BITS - data width
// Signals:    valid - beat valid; ready - downstream accept; data - beat data;
//             last  - final beat of burst, qualified by valid
// Modports:   master - stream producer (fifo_rd_stream); slave - stream consumer
interface fifo_rd_stream_if #(
    parameter int BITS = 32
);
    logic            valid;
    logic            ready;
    logic [BITS-1:0] data;
    logic            last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side consumer re-presenting beats as a bursted valid/ready stream
// Ports:
//   rd_clk, rd_rst_n  clock and async active-low reset shared with the FIFO read side
//   en                1 = fetch from FIFO, 0 = stop fetching and drain the buffer
//   idle              1 = nothing buffered or in flight, not fetching
//   rd_en, rd_empty, rd_data  FIFO read port (data valid the cycle after rd_en)
//   m                 output stream (valid/ready/data/last), last on beat BURST_LEN of each burst
// Optional macro FIFO_RD_STREAM_STALL_CNT_EN adds stall_cnt[15:0]: saturating count of
//   cycles with valid && !ready.
module fifo_rd_stream #(
    parameter int BITS      = 32,
    parameter int BUF_DEPTH = 3,
    parameter int BURST_LEN = 8
) (
    input  logic             rd_clk,
    input  logic             rd_rst_n,
    input  logic             en,
    output logic             idle,
    output logic             rd_en,
    input  logic             rd_empty,
    input  logic [BITS-1:0]  rd_data,
    fifo_rd_stream_if.master m
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX  = CW'(BUF_DEPTH - 1);
    localparam logic [CW-1:0] FULL      = CW'(BUF_DEPTH);
    localparam logic [CW:0]   CREDITS   = (CW + 1)'(BUF_DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   head;
    logic [CW-1:0]   tail;
    logic            inflight;
    logic [BW-1:0]   beat_cnt;
    logic [BITS-1:0] mem [BUF_DEPTH];
    logic            valid;
    logic            push;
    logic            pop;
    logic [CW:0]     occupancy;

    assign valid     = (count != '0);
    assign push      = inflight;
    assign pop       = valid && m.ready;
    // Credit counts reads already issued but not yet landed; a pop in the same
    // cycle is deliberately not credited so rd_en never depends on m.ready.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};

    assign idle   = (state == IDLE);
    assign m.valid = valid;
    assign m.data  = valid ? mem[head] : '0;
    assign m.last  = valid && (beat_cnt == LAST_BEAT);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = RUN;
            end
            RUN: begin
                rd_en = !rd_empty && (occupancy < CREDITS);
                if (!en) state_nxt = DRAIN;
            end
            DRAIN: begin
                if ((count == '0) && !inflight) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= 1'b0;
            beat_cnt <= '0;
        end else begin
            inflight <= rd_en;
            if (push) tail <= (tail == LAST_IDX) ? '0 : tail + CW'(1);
            if (pop)  head <= (head == LAST_IDX) ? '0 : head + CW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Burst position survives en/IDLE so bursts are never cut short.
            if (pop) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BW'(1);
        end
    end

    // Storage needs no reset: m.data is gated by valid.
    always_ff @(posedge rd_clk) begin
        if (push) mem[tail] <= rd_data;
    end

`ifdef FIFO_RD_STREAM_STALL_CNT_EN
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            stall_cnt <= '0;
        end else if (valid && !m.ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    a_no_push_when_full: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        !(push && (count == FULL)));
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard testbench for fifo_rd_stream
module tb_fifo_rd_stream;
    localparam int BITS = 32;
    localparam int BL   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, en, idle, rd_en, rd_empty;
    logic [BITS-1:0] rd_data;
    logic            en2, idle2, rd_en2, rd_empty2;
    logic [BITS-1:0] rd_data2;
    fifo_rd_stream_if #(.BITS(BITS)) s0 ();
    fifo_rd_stream_if #(.BITS(BITS)) s1 ();
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
    logic [15:0] stall_cnt, stall_cnt2;
`endif

    fifo_rd_stream #(.BITS(BITS), .BUF_DEPTH(3), .BURST_LEN(BL)) dut (
        .rd_clk(clk), .rd_rst_n(rst_n), .en(en), .idle(idle), .rd_en(rd_en),
        .rd_empty(rd_empty), .rd_data(rd_data), .m(s0)
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    fifo_rd_stream #(.BITS(BITS), .BUF_DEPTH(2), .BURST_LEN(BL)) dut2 (
        .rd_clk(clk), .rd_rst_n(rst_n), .en(en2), .idle(idle2), .rd_en(rd_en2),
        .rd_empty(rd_empty2), .rd_data(rd_data2), .m(s1)
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
        , .stall_cnt(stall_cnt2)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int beats0   = 0;
    int beats1   = 0;
    int mon_cnt0 = 0;
    int mon_cnt1 = 0;
    logic [BITS-1:0] fq0[$], sb0[$], fq1[$], sb1[$];
    logic fetch0 = 1'b0;
    logic fetch1 = 1'b0;

    always @(posedge clk) cyc++;

    // FIFO models: one-cycle read latency, empty flag follows the queue.
    always @(negedge clk) begin
        fetch0 = rd_en;
        fetch1 = rd_en2;
        if (rst_n && rd_empty) begin
            n_checks++;
            if (rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_en_while_empty: rd_en=%b required 0", rd_en);
            end
        end
        if (rst_n && rd_empty2) begin
            n_checks++;
            if (rd_en2 !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_en2_while_empty: rd_en=%b required 0", rd_en2);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (fetch0 && fq0.size() > 0) rd_data = fq0.pop_front();
        if (fetch1 && fq1.size() > 0) rd_data2 = fq1.pop_front();
        rd_empty  = (fq0.size() == 0);
        rd_empty2 = (fq1.size() == 0);
    end

    // Scoreboard monitors: data order and burst framing.
    always @(negedge clk) begin
        logic [BITS-1:0] exp;
        if (rst_n && s0.valid && s0.ready) begin
            n_checks++;
            if (sb0.size() == 0) begin
                n_fail++;
                $display("FAIL beat0_unexpected: data=%h required none", s0.data);
            end else begin
                exp = sb0.pop_front();
                if (s0.data !== exp || s0.last !== (mon_cnt0 == BL - 1)) begin
                    n_fail++;
                    $display("FAIL beat0: data=%h last=%b required data=%h last=%b",
                             s0.data, s0.last, exp, (mon_cnt0 == BL - 1));
                end
            end
            mon_cnt0 = (mon_cnt0 == BL - 1) ? 0 : mon_cnt0 + 1;
            beats0++;
        end
        if (rst_n && s1.valid && s1.ready) begin
            n_checks++;
            if (sb1.size() == 0) begin
                n_fail++;
                $display("FAIL beat1_unexpected: data=%h required none", s1.data);
            end else begin
                exp = sb1.pop_front();
                if (s1.data !== exp || s1.last !== (mon_cnt1 == BL - 1)) begin
                    n_fail++;
                    $display("FAIL beat1: data=%h last=%b required data=%h last=%b",
                             s1.data, s1.last, exp, (mon_cnt1 == BL - 1));
                end
            end
            mon_cnt1 = (mon_cnt1 == BL - 1) ? 0 : mon_cnt1 + 1;
            beats1++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load0(input int n, input logic [BITS-1:0] base);
        for (int i = 0; i < n; i++) begin
            fq0.push_back(base + BITS'(i));
            sb0.push_back(base + BITS'(i));
        end
    endtask

    task automatic load1(input int n, input logic [BITS-1:0] base);
        for (int i = 0; i < n; i++) begin
            fq1.push_back(base + BITS'(i));
            sb1.push_back(base + BITS'(i));
        end
    endtask

    task automatic drain0(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb0.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        en = 1'b0;
        en2 = 1'b0;
        s0.ready = 1'b0;
        fq0.delete(); sb0.delete(); fq1.delete(); sb1.delete();
        mon_cnt0 = 0;
        mon_cnt1 = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if (idle !== 1'b1 || rd_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: idle=%b rd_en=%b required 1 0", idle, rd_en);
        end
        n_checks++;
        if (s0.valid !== 1'b0 || s0.last !== 1'b0) begin
            n_fail++; $display("FAIL reset_stream: valid=%b last=%b required 0 0", s0.valid, s0.last);
        end
        n_checks++;
        if (s0.data !== '0) begin
            n_fail++; $display("FAIL reset_data: data=%h required 0", s0.data);
        end
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_stall_cnt: %0d required 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_burst;
        int t_rd, t_v, t_l, b0;
        t_rd = -1; t_v = -1; t_l = -1;
        do_reset();
        b0 = beats0;
        load0(8, 32'hA0);
        s0.ready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rd_en && t_rd < 0) t_rd = cyc;
            if (s0.valid) begin
                if (t_v < 0) t_v = cyc;
                t_l = cyc;
            end
        end
        n_checks++;
        if (t_rd < 0 || t_v - t_rd != 2) begin
            n_fail++; $display("FAIL burst_latency: %0d cycles required 2", t_v - t_rd);
        end
        n_checks++;
        if (beats0 - b0 != 8) begin
            n_fail++; $display("FAIL burst_count: %0d beats required 8", beats0 - b0);
        end
        n_checks++;
        if (t_l - t_v != 7) begin
            n_fail++; $display("FAIL burst_back_to_back: span %0d required 7", t_l - t_v);
        end
        en = 1'b0;
    endtask

    task automatic test_backpressure;
        int nrd;
        bit stable, ok;
        nrd = 0; stable = 1'b1;
        do_reset();
        load0(6, 32'hB0);
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rd_en) nrd++;
            if (s0.valid && s0.data !== 32'hB0) stable = 1'b0;
        end
        n_checks++;
        if (nrd != 3) begin
            n_fail++; $display("FAIL bp_reads: %0d required 3", nrd);
        end
        n_checks++;
        if (dut.count !== 2'd3) begin
            n_fail++; $display("FAIL bp_count: %0d required 3", dut.count);
        end
        n_checks++;
        if (s0.valid !== 1'b1 || s0.data !== 32'hB0 || !stable) begin
            n_fail++; $display("FAIL bp_hold: valid=%b data=%h stable=%b required 1 b0 1",
                               s0.valid, s0.data, stable);
        end
        tick();
        s0.ready = 1'b1;
        drain0(40, ok);
        n_checks++;
        if (!ok || fq0.size() != 0) begin
            n_fail++; $display("FAIL bp_release: left=%0d required 0", sb0.size());
        end
        en = 1'b0;
    endtask

    task automatic test_en_drop;
        int nrd, b0;
        bit ok;
        nrd = 0;
        do_reset();
        b0 = beats0;
        load0(5, 32'hC0);
        s0.ready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 20 && nrd < 3; i++) begin
            @(negedge clk);
            if (rd_en) nrd++;
        end
        en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (idle) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || rd_en !== 1'b0) begin
            n_fail++; $display("FAIL drop_idle: idle=%b rd_en=%b required 1 0", idle, rd_en);
        end
        n_checks++;
        if (fq0.size() != 2 || beats0 - b0 != 3) begin
            n_fail++; $display("FAIL drop_split: fifo=%0d beats=%0d required 2 3",
                               fq0.size(), beats0 - b0);
        end
        load0(3, 32'hC5);
        tick();
        en = 1'b1;
        drain0(40, ok);
        n_checks++;
        if (!ok || beats0 - b0 != 8) begin
            n_fail++; $display("FAIL drop_resume: beats=%0d required 8", beats0 - b0);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        do_reset();
        load0(3, 32'hD0);
        s0.ready = 1'b1;
        en = 1'b1;
        drain0(30, ok);
        tick();
        s0.ready = 1'b0;
        load0(6, 32'hD3);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut.count == 2'd2) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rst_mid_fill: count=%0d required 2", dut.count);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (s0.valid !== 1'b0 || rd_en !== 1'b0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_async: valid=%b rd_en=%b idle=%b required 0 0 1",
                               s0.valid, rd_en, idle);
        end
        fq0.delete(); sb0.delete();
        mon_cnt0 = 0;
        en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        load0(8, 32'hE0);
        s0.ready = 1'b1;
        en = 1'b1;
        drain0(40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rst_mid_resume: left=%0d required 0", sb0.size());
        end
        en = 1'b0;
    endtask

    task automatic test_depth2;
        int b1, t0, tl;
        b1 = beats1; t0 = -1; tl = -1;
        do_reset();
        load1(16, 32'h100);
        en2 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (s1.valid) begin
                if (t0 < 0) t0 = cyc;
                tl = cyc;
            end
        end
        n_checks++;
        if (beats1 - b1 != 16) begin
            n_fail++; $display("FAIL d2_count: %0d beats required 16", beats1 - b1);
        end
        n_checks++;
        if (tl - t0 <= 15) begin
            n_fail++; $display("FAIL d2_rate: span %0d required more than 15", tl - t0);
        end
        en2 = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (idle2 !== 1'b1) begin
            n_fail++; $display("FAIL d2_idle: idle=%b required 1", idle2);
        end
    endtask

`ifdef FIFO_RD_STREAM_STALL_CNT_EN
    task automatic test_stall_cnt;
        bit ok;
        do_reset();
        load0(1, 32'h55);
        en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s0.valid) begin ok = 1'b1; break; end
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (!ok || stall_cnt !== 16'd10) begin
            n_fail++; $display("FAIL stall_10: %0d required 10", stall_cnt);
        end
        repeat (70000) @(negedge clk);
        n_checks++;
        if (stall_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL stall_sat: %h required ffff", stall_cnt);
        end
        n_checks++;
        if (stall_cnt2 !== 16'd0) begin
            n_fail++; $display("FAIL stall2_zero: %0d required 0", stall_cnt2);
        end
        tick();
        s0.ready = 1'b1;
        drain0(10, ok);
        en = 1'b0;
    endtask
`endif

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; en2 = 1'b0;
        s0.ready = 1'b0; s1.ready = 1'b1;
        rd_empty = 1'b1; rd_empty2 = 1'b1;
        rd_data = '0; rd_data2 = '0;
        test_reset();
        test_burst();
        test_backpressure();
        test_en_drop();
        test_reset_mid();
        test_depth2();
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
